systolic_mm_engine: RTL
=======================

SYSTOLIC_MM_ENGINE -- requirements
Module: systolic_mm_engine

Interface
REQ-001 SHALL have parameter WIDTH, default 8: signed operand element width in bits.
REQ-002 SHALL have parameter SIZE, default 4: matrix dimension (SIZE x SIZE), legal range 2..16.
REQ-003 SHALL have parameter ACC_WIDTH, default 2*WIDTH+$clog2(SIZE): signed result element width, at least 2*WIDTH.
REQ-004 SHALL have port clk, input, 1 bit: single clock; all logic on rising edge.
REQ-005 SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-006 SHALL have port start, input, 1 bit: request to multiply; sampled only in IDLE.
REQ-007 SHALL have port acc_en, input, 1 bit: sampled with start; 1 = C_new = C_old + A*B, 0 = C_new = A*B.
REQ-008 SHALL have port A, input, signed [WIDTH-1:0] [0:SIZE-1][0:SIZE-1]: left operand, sampled with start.
REQ-009 SHALL have port B, input, signed [WIDTH-1:0] [0:SIZE-1][0:SIZE-1]: right operand, sampled with start.
REQ-010 SHALL have port busy, output, 1 bit: high in LOAD, COMPUTE or DONE.
REQ-011 SHALL have port out_valid, output, 1 bit: C holds a complete result.
REQ-012 SHALL have port out_ready, input, 1 bit: consumer accepts C when out_valid and out_ready are both high.
REQ-013 SHALL have port C, output, signed [ACC_WIDTH-1:0] [0:SIZE-1][0:SIZE-1]: result matrix.

Function
REQ-014 SHALL implement FSM states IDLE, LOAD, COMPUTE, DONE.
REQ-015 SHALL, in IDLE with start=1, register A, B and acc_en and go to LOAD; start=0 stays IDLE.
REQ-016 SHALL, in LOAD (one cycle), clear all PE accumulators if the latched acc_en=0, keep them if 1, clear the step counter, and go to COMPUTE.
REQ-017 SHALL contain a SIZE x SIZE grid of output-stationary PEs; A values move one column right per cycle, B values one row down per cycle.
REQ-018 SHALL skew inputs internally: A[i][k] enters row i's left edge at step k+i; B[k][j] enters column j's top edge at step k+j; zeros are injected outside 0<=k<SIZE.
REQ-019 SHALL have PE(i,j) perform acc += a*b at step k+i+j, using the full signed 2*WIDTH product sign-extended to ACC_WIDTH.
REQ-020 SHALL wrap accumulation modulo 2^ACC_WIDTH with no saturation.
REQ-021 SHALL run COMPUTE for exactly 3*SIZE-2 steps (steps 0..3*SIZE-3), one step per cycle, then go to DONE.
REQ-022 SHALL, in DONE, drive C[i][j] from PE(i,j)'s accumulator, assert out_valid, and hold C stable while out_valid=1 and out_ready=0.
REQ-023 SHALL, in DONE with out_ready=1, deassert out_valid next cycle and return to IDLE; accumulators retain their values for a later acc_en=1 run.
REQ-024 SHALL give a latency of 3*SIZE cycles from the start-sampling edge to the first cycle out_valid=1 (12 for SIZE=4).
REQ-025 SHALL ignore start while busy=1; operands of an in-flight job are unaffected.
REQ-026 SHALL let start asserted in the same cycle DONE is accepted take effect only once the FSM is in IDLE, with no back-to-back overlap.

Reset
REQ-027 SHALL, with rst=1 at a clock edge, set state IDLE, busy=0, out_valid=0, step counter 0, all accumulators and pipeline registers 0, and C=0; this applies in every state.
REQ-028 SHALL give rst priority over start and out_ready in the same cycle; an interrupted job produces no result.

Verification
REQ-029 SHALL be verified by: SIZE=4, A=identity, B[i][j]=4*i+j, acc_en=0 -> after 12 cycles out_valid=1 and C[i][j]=4*i+j.
REQ-030 SHALL be verified by: SIZE=4, all A=-128, all B=-128 -> every C element = 65536 (no overflow with ACC_WIDTH=18).
REQ-031 SHALL be verified by: run A=B=identity, then run again with acc_en=1 on the same operands -> C diagonal=2, off-diagonal=0.
REQ-032 SHALL be verified by: out_ready held 0 for 5 cycles in DONE -> out_valid stays 1 and C stays unchanged; out_ready=1 -> out_valid=0 next cycle and busy=0.
REQ-033 SHALL be verified by: start pulsed during COMPUTE with different A -> result matches the first operands only.
REQ-034 SHALL be verified by: rst asserted at COMPUTE step 3 -> next cycle busy=0, out_valid=0, C=0; a fresh job then yields the correct result.

Source files
------------

// File: rtl/systolic_mm_engine.sv
// SIZE x SIZE output-stationary systolic matrix multiplier, C = A*B or C += A*B.
// Latency 3*SIZE cycles from start to out_valid; C is held while out_valid && !out_ready, and start is ignored while busy.
module systolic_mm_engine #(
    parameter int WIDTH     = 8,
    parameter int SIZE      = 4,
    parameter int ACC_WIDTH = 2*WIDTH + $clog2(SIZE)
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        start,
    input  logic                        acc_en,
    input  logic signed [WIDTH-1:0]     A [0:SIZE-1][0:SIZE-1],
    input  logic signed [WIDTH-1:0]     B [0:SIZE-1][0:SIZE-1],
    output logic                        busy,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic signed [ACC_WIDTH-1:0] C [0:SIZE-1][0:SIZE-1]
);

    localparam int STEPS = 3*SIZE - 2;
    localparam int SW    = $clog2(STEPS + 1);

    localparam logic [1:0] IDLE    = 2'd0;
    localparam logic [1:0] LOAD    = 2'd1;
    localparam logic [1:0] COMPUTE = 2'd2;
    localparam logic [1:0] DONE    = 2'd3;

    logic [1:0]                  state;
    logic [SW-1:0]               step;
    logic                        acc_en_r;
    logic signed [WIDTH-1:0]     a_r    [0:SIZE-1][0:SIZE-1];
    logic signed [WIDTH-1:0]     b_r    [0:SIZE-1][0:SIZE-1];
    logic signed [WIDTH-1:0]     a_pipe [0:SIZE-1][0:SIZE-1];
    logic signed [WIDTH-1:0]     b_pipe [0:SIZE-1][0:SIZE-1];
    logic signed [ACC_WIDTH-1:0] acc    [0:SIZE-1][0:SIZE-1];

    logic signed [WIDTH-1:0]     a_edge [0:SIZE-1];
    logic signed [WIDTH-1:0]     b_edge [0:SIZE-1];
    logic signed [WIDTH-1:0]     a_in   [0:SIZE-1][0:SIZE-1];
    logic signed [WIDTH-1:0]     b_in   [0:SIZE-1][0:SIZE-1];
    logic signed [2*WIDTH-1:0]   prod   [0:SIZE-1][0:SIZE-1];

    assign busy = (state != IDLE);

    // Edge skew: row i sees A[i][k] at step k+i, column j sees B[k][j] at step k+j, zero otherwise.
    always_comb begin
        for (int i = 0; i < SIZE; i++) begin
            a_edge[i] = '0;
            b_edge[i] = '0;
            for (int k = 0; k < SIZE; k++) begin
                if (int'(step) == k + i) begin
                    a_edge[i] = a_r[i][k];
                    b_edge[i] = b_r[k][i];
                end
            end
        end
    end

    always_comb begin
        for (int i = 0; i < SIZE; i++) begin
            a_in[i][0] = a_edge[i];
            b_in[0][i] = b_edge[i];
            for (int j = 1; j < SIZE; j++) begin
                a_in[i][j] = a_pipe[i][j-1];
                b_in[j][i] = b_pipe[j-1][i];
            end
        end
        for (int i = 0; i < SIZE; i++) begin
            for (int j = 0; j < SIZE; j++) begin
                prod[i][j] = a_in[i][j] * b_in[i][j];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            step      <= '0;
            out_valid <= 1'b0;
            acc_en_r  <= 1'b0;
            for (int i = 0; i < SIZE; i++) begin
                for (int j = 0; j < SIZE; j++) begin
                    a_r[i][j]    <= '0;
                    b_r[i][j]    <= '0;
                    a_pipe[i][j] <= '0;
                    b_pipe[i][j] <= '0;
                    acc[i][j]    <= '0;
                    C[i][j]      <= '0;
                end
            end
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        a_r      <= A;
                        b_r      <= B;
                        acc_en_r <= acc_en;
                        state    <= LOAD;
                    end
                end
                LOAD: begin
                    step <= '0;
                    for (int i = 0; i < SIZE; i++) begin
                        for (int j = 0; j < SIZE; j++) begin
                            a_pipe[i][j] <= '0;
                            b_pipe[i][j] <= '0;
                            if (!acc_en_r) begin
                                acc[i][j] <= '0;
                            end
                        end
                    end
                    state <= COMPUTE;
                end
                COMPUTE: begin
                    for (int i = 0; i < SIZE; i++) begin
                        for (int j = 0; j < SIZE; j++) begin
                            a_pipe[i][j] <= a_in[i][j];
                            b_pipe[i][j] <= b_in[i][j];
                            acc[i][j]    <= acc[i][j] + ACC_WIDTH'(prod[i][j]);
                        end
                    end
                    step <= step + 1'b1;
                    if (step == SW'(STEPS - 1)) begin
                        state <= DONE;
                    end
                end
                DONE: begin
                    // First DONE cycle captures the accumulators; C is then frozen until accepted.
                    if (!out_valid) begin
                        C         <= acc;
                        out_valid <= 1'b1;
                    end else if (out_ready) begin
                        out_valid <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
